// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared constants for the UART receive path: FSM state encoding, the
//   oversampling ratio and the mid-bit sample point, plus a helper that
//   sizes the tick counter so it can also span a long stop bit.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Tick counter needs 4 bits for a 16x bit period, more when the stop
    // bit is 1.5 or 2 bit times long.
    function automatic int cnt_width(input int sb_tick);
        int w;
        w = $clog2(sb_tick);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
//   Two-flop synchroniser for a single asynchronous input.
//   Ports:
//     clk      in  system clock
//     reset_n  in  asynchronous active-low reset (both flops load RST_VAL)
//     d        in  asynchronous input
//     q        out synchronised output
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   Serial-to-parallel UART receiver driven by a 16x oversample tick.
//   Finds start + DBIT data (LSB first) + stop, samples each bit mid-period.
//   Ports:
//     clk           in   system clock
//     reset_n       in   asynchronous active-low reset
//     s_tick        in   16x baud enable, one clk wide
//     rx            in   serial line, idle high, asynchronous
//     dout          out  last successfully received word
//     rx_done_tick  out  one-clk strobe, dout updated this cycle
//     frame_err     out  one-clk strobe, stop bit sampled low
//     busy          out  receiver not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = cnt_width(SB_TICK);
    localparam int NW = $clog2(DBIT);

    logic            rx_s;
    logic [2:0]      state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic [DBIT-1:0] dout_n;
    logic            done_n, ferr_n;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            dout         <= dout_n;
            rx_done_tick <= done_n;
            frame_err    <= ferr_n;
        end
    end

    // Only IDLE->START and WAIT->IDLE are tick-independent; every other
    // move is gated by s_tick so the frame timing is counted in ticks.
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        dout_n  = dout;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(MID_SAMPLE)) begin
                        // Still low at mid start bit: real frame, else a glitch.
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(OVERSAMPLE - 1)) begin
                        s_n = '0;
                        b_n = {rx_s, b[DBIT-1:1]};
                        if (n == NW'(DBIT - 1))
                            state_n = STOP;
                        else
                            n_n = n + 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            dout_n  = b;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = WAIT;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            WAIT: begin
                // A held-low line (break) must release before the next frame.
                if (rx_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
